// File: rtl/lcd_seq.sv
// HD44780-style character LCD write sequencer: power-up init, then one byte per REQ toggle
// with a setup/enable/hold strobe and a command-dependent settle wait.
module lcd_seq #(
   parameter int SETUP_CYC      = 4,
   parameter int EN_CYC         = 25,
   parameter int HOLD_CYC       = 2,
   parameter int SHORT_WAIT_CYC = 2000,
   parameter int LONG_WAIT_CYC  = 82000,
   parameter int INIT_WAIT_CYC  = 750000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] lcd_cmd_i,
   output logic        lcd_busy_o,
   output logic        lcd_ack_o,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic        lcd_on_o,
   output logic        lcd_blon_o
);

   typedef enum logic [2:0] {
      S_INIT_WAIT, S_INIT_LOAD, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic        init_q, init_d;
   logic        req_q, req_d;
   logic        ack_q, ack_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        on_q, blon_q;
   logic        cnt_last;
   logic        unused_cmd;

   assign unused_cmd = ^{lcd_cmd_i[29:12], lcd_cmd_i[10], lcd_cmd_i[8]};

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      case (i)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   // Clear-display and return-home are the only slow instructions.
   function automatic logic is_long(input logic rs, input logic [7:0] d);
      return !rs && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
   endfunction

   assign cnt_last = (cnt_q <= 32'd1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 32'd1;
      idx_d   = idx_q;
      init_d  = init_q;
      req_d   = req_q;
      ack_d   = ack_q;
      rs_d    = rs_q;
      data_d  = data_q;
      case (state_q)
         S_INIT_WAIT: if (cnt_last) state_d = S_INIT_LOAD;
         S_INIT_LOAD: begin
            // Init bytes carry the current ack as their REQ so completion leaves ack unchanged.
            data_d  = init_byte(idx_q);
            rs_d    = 1'b0;
            req_d   = ack_q;
            state_d = S_SETUP;
            cnt_d   = 32'(SETUP_CYC);
         end
         S_IDLE: begin
            cnt_d = cnt_q;
            if (lcd_cmd_i[11] != ack_q) begin
               data_d  = lcd_cmd_i[7:0];
               rs_d    = lcd_cmd_i[9];
               req_d   = lcd_cmd_i[11];
               state_d = S_SETUP;
               cnt_d   = 32'(SETUP_CYC);
            end
         end
         S_SETUP: if (cnt_last) begin
            state_d = S_PULSE;
            cnt_d   = 32'(EN_CYC);
         end
         S_PULSE: if (cnt_last) begin
            state_d = S_HOLD;
            cnt_d   = 32'(HOLD_CYC);
         end
         S_HOLD: if (cnt_last) begin
            state_d = S_WAIT;
            cnt_d   = is_long(rs_q, data_q) ? 32'(LONG_WAIT_CYC) : 32'(SHORT_WAIT_CYC);
         end
         S_WAIT: if (cnt_last) begin
            ack_d = req_q;
            if (init_q && idx_q != 2'd3) begin
               idx_d   = idx_q + 2'd1;
               state_d = S_INIT_LOAD;
            end else begin
               init_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_INIT_WAIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_INIT_WAIT;
         cnt_q   <= 32'(INIT_WAIT_CYC);
         idx_q   <= 2'd0;
         init_q  <= 1'b1;
         req_q   <= 1'b0;
         ack_q   <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         on_q    <= 1'b0;
         blon_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         init_q  <= init_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         on_q    <= lcd_cmd_i[31];
         blon_q  <= lcd_cmd_i[30];
      end
   end

   assign lcd_busy_o = (state_q != S_IDLE);
   assign lcd_ack_o  = ack_q;
   assign lcd_data_o = data_q;
   assign lcd_rs_o   = rs_q;
   assign lcd_rw_o   = 1'b0;
   assign lcd_en_o   = (state_q == S_PULSE);
   assign lcd_on_o   = on_q;
   assign lcd_blon_o = blon_q;

endmodule

// File: tb/tb_lcd_seq.sv
// Randomized bench for lcd_seq: a timeline model predicts every pin per cycle from the
// slot start times and phase lengths; includes a reset issued while EN is high.
module tb_lcd_seq;

   localparam int S  = 2;
   localparam int E  = 3;
   localparam int H  = 1;
   localparam int SW = 5;
   localparam int LW = 20;
   localparam int IW = 10;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] lcd_cmd_i = '0;
   logic        lcd_busy_o, lcd_ack_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o;
   logic [7:0]  lcd_data_o;

   lcd_seq #(
      .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
      .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW), .INIT_WAIT_CYC(IW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .lcd_cmd_i(lcd_cmd_i),
      .lcd_busy_o(lcd_busy_o), .lcd_ack_o(lcd_ack_o), .lcd_data_o(lcd_data_o),
      .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_en_o(lcd_en_o),
      .lcd_on_o(lcd_on_o), .lcd_blon_o(lcd_blon_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference timeline
   logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
   bit         in_init, slot_act, slot_rs, slot_req;
   int         n_init, slot_l, slot_w;
   logic [7:0] slot_data;
   logic       exp_ack, exp_rs, exp_on, exp_blon, pend_on, pend_blon;
   logic [7:0] exp_data;
   bit         did_rst = 0;
   int         n_tx = 0;
   int         n_long = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      in_init  = 1; n_init = 0; slot_act = 0;
      exp_ack  = 0; exp_rs = 0; exp_data = 8'h00;
      exp_on   = 0; exp_blon = 0;
   endtask

   task automatic start_slot(input int l, input logic [7:0] d, input logic rs, input logic rq);
      slot_act  = 1; slot_l = l; slot_data = d; slot_rs = rs; slot_req = rq;
      slot_w    = (!rs && d[7:2] == 6'd0 && d[1:0] != 2'd0) ? LW : SW;
      if (slot_w == LW) n_long++;
   endtask

   task automatic model_advance();
      exp_on   = pend_on;
      exp_blon = pend_blon;
      if (slot_act && cyc == slot_l + 1) begin
         exp_data = slot_data;
         exp_rs   = slot_rs;
      end
      if (slot_act && cyc == slot_l + 1 + S + E + H + slot_w) begin
         slot_act = 0;
         exp_ack  = slot_req;
         if (in_init) begin
            if (n_init < 4) begin
               start_slot(cyc, init_tab[n_init], 1'b0, exp_ack);
               n_init++;
            end else begin
               in_init = 0;
            end
         end
      end
      if (in_init && n_init == 0 && cyc == IW) begin
         start_slot(cyc, init_tab[0], 1'b0, exp_ack);
         n_init = 1;
      end
   endtask

   task automatic check_outputs();
      logic eb, ee;
      eb = in_init || (slot_act && cyc > slot_l);
      ee = slot_act && (cyc > slot_l + S) && (cyc <= slot_l + S + E);
      chk("busy", lcd_busy_o, eb);
      chk("ack",  lcd_ack_o,  exp_ack);
      chk("en",   lcd_en_o,   ee);
      chk("data", lcd_data_o, exp_data);
      chk("rs",   lcd_rs_o,   exp_rs);
      chk("rw",   lcd_rw_o,   1'b0);
      chk("on",   lcd_on_o,   exp_on);
      chk("blon", lcd_blon_o, exp_blon);
   endtask

   task automatic drive();
      if ($urandom_range(0, 19) == 0) lcd_cmd_i[31] = ~lcd_cmd_i[31];
      if ($urandom_range(0, 29) == 0) lcd_cmd_i[30] = ~lcd_cmd_i[30];
      if ($urandom_range(0, 5) == 0) begin
         case ($urandom_range(0, 6))
            0: lcd_cmd_i[7:0] = 8'h01;
            1: lcd_cmd_i[7:0] = 8'h02;
            2: lcd_cmd_i[7:0] = 8'h03;
            3: lcd_cmd_i[7:0] = 8'h80;
            4: lcd_cmd_i[7:0] = 8'h04;
            5: lcd_cmd_i[7:0] = 8'h41;
            default: lcd_cmd_i[7:0] = 8'($urandom);
         endcase
         lcd_cmd_i[9] = 1'($urandom_range(0, 1));
         lcd_cmd_i[29:12] = 18'($urandom);
         lcd_cmd_i[10] = 1'($urandom_range(0, 1));
         lcd_cmd_i[8]  = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 14) == 0) lcd_cmd_i[11] = ~lcd_cmd_i[11];
      pend_on   = lcd_cmd_i[31];
      pend_blon = lcd_cmd_i[30];
   endtask

   task automatic model_accept();
      if (!in_init && !slot_act && lcd_cmd_i[11] != exp_ack) begin
         start_slot(cyc, lcd_cmd_i[7:0], lcd_cmd_i[9], lcd_cmd_i[11]);
         n_tx++;
      end
   endtask

   task automatic release_reset();
      rst_ni = 1'b1;
      cyc    = 0;
      model_reset();
      check_outputs();
      drive();
      model_accept();
   endtask

   initial begin
      lcd_cmd_i = 32'hC000_0000;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_busy", lcd_busy_o, 1'b1);
      chk("rst_ack",  lcd_ack_o,  1'b0);
      chk("rst_on",   lcd_on_o,   1'b0);
      release_reset();
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk_i);
         cyc++;
         @(negedge clk_i);
         model_advance();
         check_outputs();
         drive();
         model_accept();
         if (!did_rst && i > 2000 && slot_act && !in_init &&
             cyc > slot_l + S && cyc <= slot_l + S + E) begin
            did_rst = 1;
            #2 rst_ni = 1'b0;
            #1;
            chk("abort_en",   lcd_en_o,   1'b0);
            chk("abort_ack",  lcd_ack_o,  1'b0);
            chk("abort_busy", lcd_busy_o, 1'b1);
            chk("abort_data", lcd_data_o, 8'h00);
            chk("abort_rs",   lcd_rs_o,   1'b0);
            chk("abort_on",   lcd_on_o,   1'b0);
            @(posedge clk_i);
            @(negedge clk_i);
            release_reset();
         end
      end
      chk("reset_in_pulse_seen", did_rst, 1'b1);
      chk("tx_seen", (n_tx > 20), 1'b1);
      chk("long_seen", (n_long > 3), 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_seq.md
LCD_SEQ -- requirements
Module: lcd_seq

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 4, meaning clocks RS/DATA are stable before EN rises.
REQ-002 SHALL have parameter EN_CYC, default 25, meaning clocks EN is held high.
REQ-003 SHALL have parameter HOLD_CYC, default 2, meaning clocks RS/DATA are held after EN falls.
REQ-004 SHALL have parameter SHORT_WAIT_CYC, default 2000, meaning post-command wait for ordinary commands and data.
REQ-005 SHALL have parameter LONG_WAIT_CYC, default 82000, meaning post-command wait for clear/home.
REQ-006 SHALL have parameter INIT_WAIT_CYC, default 750000, meaning power-up delay before the init sequence.
REQ-007 SHALL have port clk_i, input, 1, the clock.
REQ-008 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port lcd_cmd_i, input, 32, the LSU LCD register: [31] ON, [30] BLON, [11] REQ toggle, [9] RS, [7:0] DATA; other bits ignored.
REQ-010 SHALL have port lcd_busy_o, output, 1, high while a transaction or init is in progress.
REQ-011 SHALL have port lcd_ack_o, output, 1, toggle acknowledge equal to the last completed REQ value.
REQ-012 SHALL have port lcd_data_o, output, 8, panel data bus.
REQ-013 SHALL have ports lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o, outputs, 1 each, panel control pins.

Function
REQ-014 SHALL implement states INIT_WAIT, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT with one shared down-counter.
REQ-015 SHALL leave INIT_WAIT after exactly INIT_WAIT_CYC clocks, then issue init bytes 0x38, 0x0C, 0x01, 0x06 in order with RS=0, each through SETUP/PULSE/HOLD/WAIT.
REQ-016 SHALL treat a request as pending in IDLE when lcd_cmd_i[11] != lcd_ack_o.
REQ-017 SHALL, on a pending request in IDLE, latch RS and DATA from lcd_cmd_i and enter SETUP on the next edge.
REQ-018 SHALL spend exactly SETUP_CYC, EN_CYC, HOLD_CYC clocks in SETUP, PULSE, HOLD respectively; lcd_en_o high only in PULSE.
REQ-019 SHALL select LONG_WAIT_CYC when latched RS=0 and DATA[7:2]=0 and DATA[1:0]!=0, else SHORT_WAIT_CYC.
REQ-020 SHALL, on WAIT expiry, set lcd_ack_o to the latched REQ value and return to IDLE (or INIT_LOAD if init bytes remain) on the same edge.
REQ-021 SHALL assert lcd_busy_o in every state except IDLE; busy falls the cycle IDLE is entered.
REQ-022 SHALL ignore changes to lcd_cmd_i[11:0] while busy; a REQ toggled an even number of times while busy yields no new transaction.
REQ-023 SHALL ignore requests during init; a request pending at init end is served from IDLE.
REQ-024 SHALL hold lcd_data_o/lcd_rs_o at latched values from SETUP through HOLD; drive lcd_rw_o constant 0.
REQ-025 SHALL register lcd_on_o and lcd_blon_o from lcd_cmd_i[31]/[30] every cycle, independent of state.
REQ-026 SHALL accept a back-to-back request one cycle after IDLE is entered (minimum one IDLE cycle).

Reset
REQ-027 SHALL, on rst_ni low, asynchronously enter INIT_WAIT with counter=INIT_WAIT_CYC, lcd_busy_o=1, lcd_ack_o=0, lcd_en_o=0, lcd_rs_o=0, lcd_data_o=0x00, lcd_on_o=0, lcd_blon_o=0.
REQ-028 SHALL abort any transaction on reset mid-operation, forcing lcd_en_o low immediately and restarting init.

Verification (bench params: SETUP=2, EN=3, HOLD=1, SHORT=5, LONG=20, INIT=10)
REQ-029 Reset release -> busy 10 clocks, then four EN pulses with DATA 0x38,0x0C,0x01,0x06; 0x01 followed by 20-clock wait; busy falls, ack=0.
REQ-030 After init, toggle REQ with RS=1 DATA=0x41 -> EN high 3 clocks starting 2 clocks after SETUP entry, RS=1, then 5-clock wait, ack toggles to 1, busy falls.
REQ-031 RS=0 DATA=0x02 -> 20-clock wait; RS=0 DATA=0x80 -> 5-clock wait.
REQ-032 Change DATA from 0x41 to 0x42 during PULSE -> lcd_data_o stays 0x41; toggle REQ twice while busy -> no second transaction.
REQ-033 Assert rst_ni low during PULSE -> lcd_en_o=0 same cycle, ack=0, init sequence restarts after release.
REQ-034 Toggle lcd_cmd_i[31] at any state -> lcd_on_o follows one clock later.
